clk_rate_ctrl: RTL and testbench

//  Runtime-configurable rate controller for the FFT clocking tree. Replaces fixed divided

---
 rtl/clk_rate_ctrl.sv | 141 ++++++++++++++
 tb/tb_clk_rate_ctrl.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rate_ctrl.sv
// clk_rate_ctrl: runtime-selectable power-of-two clock-enable / square-wave divider.
// Divide ratio is N = 2^(sel+1). A new select is taken through a valid/ready
// handshake and only takes effect at a period boundary, so the divided output
// never produces a shortened high or low phase.
module clk_rate_ctrl #(
    parameter int CNT_W       = 7,
    parameter int SEL_W       = 3,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_cfg_valid,
    input  logic [SEL_W-1:0] i_cfg_sel,
    output logic             o_cfg_ready,
    output logic             o_cfg_ack,
    output logic             o_cfg_err,
    output logic [SEL_W-1:0] o_active_sel,
    output logic             o_clk_div,
    output logic             o_tick
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    // Selects at or above this value would index past the counter.
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(CNT_W);

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] active_sel_reg, active_sel_next;
    logic [SEL_W-1:0] pend_reg, pend_next;
    logic             ack_reg, ack_next;
    logic             err_reg, err_next;

    logic [CNT_W-1:0] last_val;     // N-1 for the active ratio
    logic [CNT_W-1:0] div_hit;      // one-hot pick of cnt[active_sel]
    logic             last_cnt;
    logic             running;
    logic             cfg_take;
    logic             sel_ok;

    // N-1 = (1 << (sel+1)) - 1 is simply the low sel+1 bits set; div_hit picks
    // the counter bit whose period is N, which is the 50% square output.
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_decode
        assign last_val[gi] = ((SEL_W + 1)'(gi) <= {1'b0, active_sel_reg});
        assign div_hit[gi]  = (active_sel_reg == SEL_W'(gi)) & cnt_reg[gi];
    end

    assign last_cnt     = (cnt_reg == last_val);
    assign running      = (state_reg != ST_IDLE);
    assign o_cfg_ready  = (state_reg != ST_PENDING);
    assign cfg_take     = i_cfg_valid & o_cfg_ready;
    assign sel_ok       = ({1'b0, i_cfg_sel} < SEL_LIMIT);
    assign o_cfg_ack    = ack_reg;
    assign o_cfg_err    = err_reg;
    assign o_active_sel = active_sel_reg;
    assign o_clk_div    = running & (|div_hit);
    assign o_tick       = running & last_cnt;

    // Next-state logic: run/halt control, handshake and boundary-aligned switch.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        active_sel_next = active_sel_reg;
        pend_next       = pend_reg;
        ack_next        = 1'b0;
        err_next        = cfg_take & ~sel_ok;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (cfg_take && sel_ok) begin
                    active_sel_next = i_cfg_sel;
                    ack_next        = 1'b1;
                end
                if (i_run) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_run) begin
                    // Halting: nothing to protect, so a new select applies at once.
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    if (cfg_take && sel_ok) begin
                        active_sel_next = i_cfg_sel;
                        ack_next        = 1'b1;
                    end
                end else begin
                    // The current period always finishes under the old ratio,
                    // even when the select arrives on its last cycle.
                    cnt_next = last_cnt ? '0 : cnt_reg + 1'b1;
                    if (cfg_take && sel_ok) begin
                        pend_next  = i_cfg_sel;
                        state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                if (!i_run) begin
                    state_next      = ST_IDLE;
                    cnt_next        = '0;
                    active_sel_next = pend_reg;
                    ack_next        = 1'b1;
                end else if (last_cnt) begin
                    state_next      = ST_RUN;
                    cnt_next        = '0;
                    active_sel_next = pend_reg;
                    ack_next        = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State registers; reset also discards any pending select.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            active_sel_reg <= SEL_W'(DEFAULT_SEL);
            pend_reg       <= '0;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            active_sel_reg <= active_sel_next;
            pend_reg       <= pend_next;
            ack_reg        <= ack_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_clk_rate_ctrl.sv
// tb_clk_rate_ctrl: directed scenarios plus randomized traffic, checked against
// a period-position reference model of the rate controller.
module tb_clk_rate_ctrl;

    localparam int CNT_W       = 7;
    localparam int SEL_W       = 3;
    localparam int DEFAULT_SEL = 0;
    localparam int VW          = SEL_W + 5;

    logic             i_clk;
    logic             i_rst;
    logic             i_run;
    logic             i_cfg_valid;
    logic [SEL_W-1:0] i_cfg_sel;
    logic             o_cfg_ready;
    logic             o_cfg_ack;
    logic             o_cfg_err;
    logic [SEL_W-1:0] o_active_sel;
    logic             o_clk_div;
    logic             o_tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_rate_ctrl #(
        .CNT_W       (CNT_W),
        .SEL_W       (SEL_W),
        .DEFAULT_SEL (DEFAULT_SEL)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_run        (i_run),
        .i_cfg_valid  (i_cfg_valid),
        .i_cfg_sel    (i_cfg_sel),
        .o_cfg_ready  (o_cfg_ready),
        .o_cfg_ack    (o_cfg_ack),
        .o_cfg_err    (o_cfg_err),
        .o_active_sel (o_active_sel),
        .o_clk_div    (o_clk_div),
        .o_tick       (o_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: position inside the current period, active ratio and
    // an optional pending select.
    typedef struct {
        bit running;
        int pos;
        int sel;
        bit pv;
        int pend;
        bit ack;
        bit err;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, bit run, bit valid, int sel);
        mstate_t r = s;
        int  n    = 1 << (s.sel + 1);
        bit  wrap = s.running && (s.pos == n - 1);
        bit  take = valid && !s.pv;
        bit  ok   = take && (sel < CNT_W);
        r.ack = 0;
        r.err = take && !ok;
        if (!s.running) begin
            r.pos     = 0;
            r.running = run;
            if (ok) begin r.sel = sel; r.ack = 1; end
        end else if (!run) begin
            r.running = 0;
            r.pos     = 0;
            if (s.pv) begin r.sel = s.pend; r.pv = 0; r.ack = 1; end
            else if (ok) begin r.sel = sel; r.ack = 1; end
        end else if (s.pv && wrap) begin
            r.sel = s.pend; r.pv = 0; r.pos = 0; r.ack = 1;
        end else begin
            r.pos = wrap ? 0 : s.pos + 1;
            if (ok) begin r.pv = 1; r.pend = sel; end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] model_vec(mstate_t s);
        int n = 1 << (s.sel + 1);
        return {!s.pv, s.ack, s.err, s.running && (s.pos >= n / 2),
                s.running && (s.pos == n - 1), SEL_W'(s.sel)};
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m <= '{running: 0, pos: 0, sel: DEFAULT_SEL, pv: 0, pend: 0, ack: 0, err: 0};
        end else begin
            m <= model_next(m, i_run, i_cfg_valid, int'(i_cfg_sel));
        end
    end

    logic [VW-1:0] dut_vec;
    assign dut_vec = {o_cfg_ready, o_cfg_ack, o_cfg_err, o_clk_div, o_tick, o_active_sel};

    localparam logic [VW-1:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, SEL_W'(DEFAULT_SEL)};

    // Advance one clock and settle outputs for sampling.
    task automatic cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=%b", dut_vec, RST_VEC);
        end
        cycle();
        n_checks++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%b exp=%b", dut_vec, RST_VEC);
        end
        $display("test_reset done");
    endtask

    task automatic test_div2();
        logic prev_div;
        i_run = 1'b1;
        cycle();
        prev_div = o_clk_div;
        n_checks++;
        if (o_clk_div !== 1'b0 || o_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL div2_first_cycle div=%b tick=%b exp div=0 tick=0", o_clk_div, o_tick);
        end
        for (int k = 1; k < 10; k++) begin
            cycle();
            n_checks++;
            if (o_clk_div !== ~prev_div || o_tick !== (k % 2 == 1) || dut_vec !== model_vec(m)) begin
                n_fail++;
                $display("FAIL div2_cycle%0d got=%b div=%b tick=%b exp=%b", k, dut_vec,
                         o_clk_div, o_tick, model_vec(m));
            end
            prev_div = o_clk_div;
        end
        $display("test_div2 done");
    endtask

    // Bring the controller to a known running select via a halted load.
    task automatic load_sel_idle(input int sel);
        i_run = 1'b0;
        cycle();
        i_cfg_valid = 1'b1;
        i_cfg_sel   = SEL_W'(sel);
        cycle();
        i_cfg_valid = 1'b0;
        n_checks++;
        if (o_active_sel !== SEL_W'(sel) || o_cfg_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_load sel=%0d ack=%b exp sel=%0d ack=1", o_active_sel, o_cfg_ack, sel);
        end
        i_run = 1'b1;
        cycle();
    endtask

    task automatic wait_pos(input int pos, input string name);
        int k;
        for (k = 0; k < 300 && !(m.running && m.pos == pos); k++) cycle();
        n_checks++;
        if (k >= 300) begin
            n_fail++;
            $display("FAIL %s_timeout waited=%0d cycles exp position=%0d", name, k, pos);
        end
    endtask

    task automatic test_switch_mid_period();
        load_sel_idle(2);
        wait_pos(3, "switch_mid");
        i_cfg_valid = 1'b1;
        i_cfg_sel   = 3'd1;
        cycle();
        i_cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (o_cfg_ready !== 1'b0 || o_clk_div !== 1'b1 || o_active_sel !== 3'd2 ||
                o_cfg_ack !== 1'b0 || o_tick !== (k == 3) || dut_vec !== model_vec(m)) begin
                n_fail++;
                $display("FAIL switch_old_period%0d got=%b exp ready=0 div=1 sel=2 tick=%0d", k,
                         dut_vec, k == 3);
            end
            cycle();
        end
        n_checks++;
        if (o_active_sel !== 3'd1 || o_cfg_ack !== 1'b1 || o_clk_div !== 1'b0 || o_cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_new_period got=%b exp sel=1 ack=1 div=0 ready=1", dut_vec);
        end
        for (int k = 1; k < 8; k++) begin
            cycle();
            n_checks++;
            if (o_cfg_ack !== 1'b0 || o_clk_div !== (k % 4 >= 2) || o_tick !== (k % 4 == 3)) begin
                n_fail++;
                $display("FAIL switch_n4_cycle%0d got=%b exp div=%0d tick=%0d", k, dut_vec,
                         k % 4 >= 2, k % 4 == 3);
            end
        end
        $display("test_switch_mid_period done");
    endtask

    task automatic test_switch_at_boundary();
        int acks = 0;
        load_sel_idle(0);
        wait_pos(1, "boundary");
        i_cfg_valid = 1'b1;
        i_cfg_sel   = 3'd3;
        cycle();
        i_cfg_valid = 1'b0;
        acks += int'(o_cfg_ack);
        n_checks++;
        if (o_active_sel !== 3'd0 || o_clk_div !== 1'b0 || o_cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_wrap_old got=%b exp sel=0 div=0 ready=0", dut_vec);
        end
        cycle();
        acks += int'(o_cfg_ack);
        n_checks++;
        if (o_active_sel !== 3'd0 || o_clk_div !== 1'b1 || o_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL boundary_old_period got=%b exp sel=0 div=1 tick=1", dut_vec);
        end
        for (int k = 0; k < 20; k++) begin
            cycle();
            acks += int'(o_cfg_ack);
            n_checks++;
            if (o_active_sel !== 3'd3 || o_clk_div !== (k % 16 >= 8) || o_tick !== (k % 16 == 15)) begin
                n_fail++;
                $display("FAIL boundary_n16_cycle%0d got=%b exp sel=3 div=%0d tick=%0d", k,
                         dut_vec, k % 16 >= 8, k % 16 == 15);
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL boundary_ack_count got=%0d exp=1", acks);
        end
        $display("test_switch_at_boundary done");
    endtask

    task automatic test_invalid_sel();
        logic [SEL_W-1:0] before_sel;
        before_sel  = o_active_sel;
        i_cfg_valid = 1'b1;
        i_cfg_sel   = 3'd7;
        cycle();
        i_cfg_valid = 1'b0;
        n_checks++;
        if (o_cfg_err !== 1'b1 || o_cfg_ready !== 1'b1 || o_active_sel !== before_sel ||
            o_cfg_ack !== 1'b0 || dut_vec !== model_vec(m)) begin
            n_fail++;
            $display("FAIL invalid_err_pulse got=%b exp err=1 ready=1 sel=%0d", dut_vec, before_sel);
        end
        for (int k = 0; k < 6; k++) begin
            cycle();
            n_checks++;
            if (o_cfg_err !== 1'b0 || o_active_sel !== before_sel || dut_vec !== model_vec(m)) begin
                n_fail++;
                $display("FAIL invalid_after%0d got=%b exp=%b", k, dut_vec, model_vec(m));
            end
        end
        $display("test_invalid_sel done");
    endtask

    task automatic test_halt_pending();
        int acks = 0;
        load_sel_idle(6);
        wait_pos(10, "halt_pending");
        i_cfg_valid = 1'b1;
        i_cfg_sel   = 3'd0;
        cycle();
        i_cfg_valid = 1'b0;
        n_checks++;
        if (o_cfg_ready !== 1'b0 || o_active_sel !== 3'd6) begin
            n_fail++;
            $display("FAIL halt_pending_entry got=%b exp ready=0 sel=6", dut_vec);
        end
        repeat (5) begin
            cycle();
            acks += int'(o_cfg_ack);
        end
        i_run = 1'b0;
        cycle();
        acks += int'(o_cfg_ack);
        n_checks++;
        if (o_clk_div !== 1'b0 || o_tick !== 1'b0 || o_active_sel !== 3'd0 ||
            o_cfg_ack !== 1'b1 || o_cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_idle got=%b exp div=0 tick=0 sel=0 ack=1 ready=1", dut_vec);
        end
        i_run = 1'b1;
        cycle();
        acks += int'(o_cfg_ack);
        n_checks++;
        if (o_tick !== 1'b0 || o_clk_div !== 1'b0) begin
            n_fail++;
            $display("FAIL rerun_cnt0 tick=%b div=%b exp tick=0 div=0", o_tick, o_clk_div);
        end
        cycle();
        acks += int'(o_cfg_ack);
        n_checks++;
        if (o_tick !== 1'b1 || o_clk_div !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_cnt1 tick=%b div=%b exp tick=1 div=1", o_tick, o_clk_div);
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL halt_ack_count got=%0d exp=1", acks);
        end
        $display("test_halt_pending done");
    endtask

    task automatic test_reset_pending();
        int acks = 0;
        load_sel_idle(3);
        wait_pos(2, "rst_pending");
        i_cfg_valid = 1'b1;
        i_cfg_sel   = 3'd1;
        cycle();
        i_cfg_valid = 1'b0;
        wait_pos(5, "rst_pending_cnt5");
        n_checks++;
        if (o_cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pending_state ready=%b exp=0", o_cfg_ready);
        end
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL rst_async got=%b exp=%b", dut_vec, RST_VEC);
        end
        #1;
        i_rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            acks += int'(o_cfg_ack);
            n_checks++;
            if (o_active_sel !== SEL_W'(DEFAULT_SEL) || o_cfg_ready !== 1'b1 || dut_vec !== model_vec(m)) begin
                n_fail++;
                $display("FAIL rst_after%0d got=%b exp=%b", k, dut_vec, model_vec(m));
            end
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL rst_ack_count got=%0d exp=0", acks);
        end
        $display("test_reset_pending done");
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            i_run       = ($urandom_range(0, 19) != 0);
            i_cfg_valid = ($urandom_range(0, 7) == 0);
            i_cfg_sel   = SEL_W'($urandom_range(0, 7));
            if (i_cfg_valid && o_cfg_ready)
                $display("cfg transfer t=%0t sel=%0d run=%0d active=%0d", $time, i_cfg_sel,
                         i_run, o_active_sel);
            cycle();
            n_checks++;
            if (dut_vec !== model_vec(m)) begin
                n_fail++;
                $display("FAIL random_cycle%0d got=%b exp=%b (ready ack err div tick sel)", k,
                         dut_vec, model_vec(m));
            end
        end
        i_cfg_valid = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        i_rst       = 1'b1;
        i_run       = 1'b0;
        i_cfg_valid = 1'b0;
        i_cfg_sel   = '0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        test_reset();
        test_div2();
        test_switch_mid_period();
        test_switch_at_boundary();
        test_invalid_sel();
        test_halt_pending();
        test_reset_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
